// File: rtl/ft245_bus_ctrl.sv
// FT245-style asynchronous FIFO bus sequencer: arbitrates the shared 8-bit bus between
// host->fabric reads and fabric->host writes, exposing both as valid/ready byte streams.
module ft245_bus_ctrl #(
  parameter int RD_PULSE = 5,
  parameter int WR_SETUP = 2,
  parameter int WR_PULSE = 5,
  parameter int WR_HOLD  = 2,
  parameter int RECOVERY = 8
) (
  input  logic       clk100,
  input  logic       rst_n,
  input  logic       FT_RX_Full_n,
  input  logic       FT_TX_Enable_n,
  input  logic       FT_PWR_n,
  input  logic [7:0] FT_DATA_IN,
  output logic [7:0] FT_DATA_OUT,
  output logic [7:0] FT_DATA_OE,
  output logic       FT_RD_Strobe_n,
  output logic       FT_WR_Strobe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy
);

  // state      | meaning
  // S_IDLE     | waiting for a request, arbitrates RX/TX
  // S_RD_ACT   | read strobe low, byte sampled on final cycle
  // S_WR_SETUP | data and OE driven ahead of the write strobe
  // S_WR_ACT   | write strobe high
  // S_WR_HLD   | strobe low, data and OE held
  // S_RECOV    | bus released, flags allowed to re-synchronise
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ACT   = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_ACT   = 3'd3;
  localparam logic [2:0] S_WR_HLD   = 3'd4;
  localparam logic [2:0] S_RECOV    = 3'd5;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(RD_PULSE - 1);
  localparam logic [CNT_W-1:0] SU_CNT  = CNT_W'(WR_SETUP - 1);
  localparam logic [CNT_W-1:0] WP_CNT  = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] HLD_CNT = CNT_W'(WR_HOLD - 1);
  localparam logic [CNT_W-1:0] REC_CNT = CNT_W'(RECOVERY - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       rxf_sync, txe_sync, pwr_sync;
  logic             rxf_s, txe_s, pwr_s;
  logic             last_grant_tx;
  logic             rx_req, tx_req;
  logic             grant_rx, grant_tx;
  logic             oe;

  assign rxf_s = rxf_sync[1];
  assign txe_s = txe_sync[1];
  assign pwr_s = pwr_sync[1];

  assign rx_req = !rxf_s && !pwr_s && !rx_valid;
  assign tx_req = !txe_s && !pwr_s && tx_valid;

  // With both directions pending, the one not served last wins.
  always_comb begin
    grant_rx = 1'b0;
    grant_tx = 1'b0;
    if (state == S_IDLE) begin
      if (rx_req && tx_req) begin
        grant_rx = last_grant_tx;
        grant_tx = !last_grant_tx;
      end else begin
        grant_rx = rx_req;
        grant_tx = tx_req;
      end
    end
  end

  assign busy       = (state != S_IDLE);
  assign FT_DATA_OE = {8{oe}};

  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      rxf_sync       <= 2'b11;
      txe_sync       <= 2'b11;
      pwr_sync       <= 2'b11;
      last_grant_tx  <= 1'b1;
      FT_RD_Strobe_n <= 1'b1;
      FT_WR_Strobe   <= 1'b0;
      FT_DATA_OUT    <= 8'h00;
      oe             <= 1'b0;
      rx_data        <= 8'h00;
      rx_valid       <= 1'b0;
      tx_ready       <= 1'b0;
    end else begin
      rxf_sync <= {rxf_sync[0], FT_RX_Full_n};
      txe_sync <= {txe_sync[0], FT_TX_Enable_n};
      pwr_sync <= {pwr_sync[0], FT_PWR_n};
      tx_ready <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (grant_rx) begin
            state          <= S_RD_ACT;
            cnt            <= RD_CNT;
            FT_RD_Strobe_n <= 1'b0;
          end else if (grant_tx) begin
            state       <= S_WR_SETUP;
            cnt         <= SU_CNT;
            tx_ready    <= 1'b1;
            FT_DATA_OUT <= tx_data;
            oe          <= 1'b1;
          end
        end
        S_RD_ACT: begin
          if (cnt == '0) begin
            rx_data        <= FT_DATA_IN;
            rx_valid       <= 1'b1;
            FT_RD_Strobe_n <= 1'b1;
            last_grant_tx  <= 1'b0;
            state          <= S_RECOV;
            cnt            <= REC_CNT;
          end else cnt <= cnt - 1'b1;
        end
        S_WR_SETUP: begin
          if (cnt == '0) begin
            FT_WR_Strobe <= 1'b1;
            state        <= S_WR_ACT;
            cnt          <= WP_CNT;
          end else cnt <= cnt - 1'b1;
        end
        S_WR_ACT: begin
          if (cnt == '0) begin
            FT_WR_Strobe <= 1'b0;
            state        <= S_WR_HLD;
            cnt          <= HLD_CNT;
          end else cnt <= cnt - 1'b1;
        end
        S_WR_HLD: begin
          if (cnt == '0) begin
            oe            <= 1'b0;
            last_grant_tx <= 1'b1;
            state         <= S_RECOV;
            cnt           <= REC_CNT;
          end else cnt <= cnt - 1'b1;
        end
        S_RECOV: begin
          if (cnt == '0) state <= S_IDLE;
          else cnt <= cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
